// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: double-buffered 4-digit seven-segment scanner with inter-digit blanking.
// Define SEVSEG_LZB_EN to blank leading zero digits (digit 0 always lit).
module sevseg_scan_ctrl #(
    parameter int unsigned DIV       = 100000,
    parameter int unsigned BLANK_CYC = 2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [3:0]  en_o,
    output logic [3:0]  digit_o,
    output logic        frame_o
);
    localparam int unsigned SW = $clog2(DIV);

    typedef enum logic {BLANK, ON} phase_t;

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   active_q, active_d, pending_q, pending_d;
    logic          pend_vld_q, pend_vld_d;
    logic [3:0]    en_q, en_d, digit_q, digit_d;
    logic          frame_q, frame_d;
    logic          slot_end, accept, lit;
    phase_t        phase_d;
`ifdef SEVSEG_LZB_EN
    logic [15:0]   upper;
`endif

    // Outputs are computed from next-state values so they line up with the registered state.
    always_comb begin
        slot_end   = enable_i && (slot_cnt_q == SW'(DIV - 1));
        frame_d    = slot_end && (sel_q == 2'd3);
        accept     = valid_i && !pend_vld_q;
        slot_cnt_d = (!enable_i || slot_end) ? '0 : slot_cnt_q + 1'b1;
        sel_d      = !enable_i ? 2'd0 : slot_end ? sel_q + 2'd1 : sel_q;
        active_d   = (frame_d && pend_vld_q) ? pending_q : active_q;
        pending_d  = accept ? data_i : pending_q;
        pend_vld_d = accept || (pend_vld_q && !frame_d);
        phase_d    = (!enable_i || slot_cnt_d < SW'(BLANK_CYC)) ? BLANK : ON;
`ifdef SEVSEG_LZB_EN
        upper      = active_d >> {sel_d, 2'b00};
        lit        = (sel_d == 2'd0) || (|upper);
`else
        lit        = 1'b1;
`endif
        en_d       = (phase_d == ON && lit) ? ~(4'b0001 << sel_d) : 4'b1111;
        digit_d    = active_d[{sel_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_cnt_q <= '0;
            sel_q      <= 2'd0;
            active_q   <= 16'h0000;
            pending_q  <= 16'h0000;
            pend_vld_q <= 1'b0;
            en_q       <= 4'b1111;
            digit_q    <= 4'h0;
            frame_q    <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            sel_q      <= sel_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            en_q       <= en_d;
            digit_q    <= digit_d;
            frame_q    <= frame_d;
        end
    end

    assign ready_o = !pend_vld_q;
    assign en_o    = en_q;
    assign digit_o = digit_q;
    assign frame_o = frame_q;
endmodule
